// File: rtl/kn_scale_pipe_pkg.sv
// Shared CORDIC fixed-point defaults and the elaboration helpers used to size
// the Kn gain adder tree.
package kn_scale_pipe_pkg;

    localparam int unsigned CORDIC_W      = 12;
    localparam int unsigned CORDIC_FXP    = 10;
    localparam int unsigned KN_NTERMS     = 6;
    // Kn ~= (512 + 128 - 32 + 16 - 4 + 1) / 1024 = 621 / 1024
    localparam logic [31:0] KN_TERM_SHIFT = 32'h0097_5420;
    localparam logic [7:0]  KN_TERM_NEG   = 8'b0000_1010;

    function automatic int unsigned acc_width(input int unsigned w);
        return 2 * w + 4;
    endfunction

    function automatic int unsigned half_up(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    function automatic int unsigned tree_depth(input int unsigned n);
        int unsigned m;
        int unsigned d;
        m = n;
        d = 0;
        while (m > 1) begin
            m = half_up(m);
            d++;
        end
        return d;
    endfunction

    function automatic int unsigned ops_at_level(input int unsigned n, input int unsigned lvl);
        int unsigned m;
        m = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            m = half_up(m);
        end
        return m;
    endfunction

endpackage

// File: rtl/kn_scale_pipe_add_level.sv
// One registered level of the Kn adder tree: N operands in, ceil(N/2) sums out.
// An odd trailing operand is carried through unchanged to keep tree levels aligned.
module kn_add_level
    import kn_scale_pipe_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 28
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           ce,
    input  logic [N*ACC_W-1:0]             din,
    output logic [half_up(N)*ACC_W-1:0]    dout
);

    localparam int unsigned M = half_up(N);

    logic [M*ACC_W-1:0] sum_d;
    logic [M*ACC_W-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < N / 2; i++) begin
            sum_d[i*ACC_W +: ACC_W] = din[2*i*ACC_W +: ACC_W] + din[(2*i+1)*ACC_W +: ACC_W];
        end
        if (N % 2 == 1) begin
            sum_d[(M-1)*ACC_W +: ACC_W] = din[(N-1)*ACC_W +: ACC_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (ce) begin
            sum_q <= sum_d;
        end
    end

    assign dout = sum_q;

endmodule

// File: rtl/kn_scale_pipe.sv
// Pipelined multiply by the CORDIC gain Kn as a signed-digit shift-add sum,
// with round-half-up, optional saturation, valid tagging and an unscaled bypass.
module kn_scale_pipe
    import kn_scale_pipe_pkg::*;
#(
    parameter int unsigned W          = CORDIC_W,
    parameter int unsigned FXP_SHIFT  = CORDIC_FXP,
    parameter int unsigned NTERMS     = KN_NTERMS,
    parameter logic [31:0] TERM_SHIFT = KN_TERM_SHIFT,
    parameter logic [7:0]  TERM_NEG   = KN_TERM_NEG,
    parameter bit          ROUND      = 1'b1,
    parameter bit          SAT        = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                valid_in,
    input  logic                bypass_in,
    input  logic signed [W-1:0] value_in,
    output logic                valid_out,
    output logic signed [W-1:0] value_out,
    output logic                sat_flag
);

    localparam int unsigned ACC_W = acc_width(W);
    localparam int unsigned L     = tree_depth(NTERMS);

    localparam logic signed [ACC_W-1:0] RND_OFS = ROUND ? ACC_W'((2 ** FXP_SHIFT) / 2) : '0;
    localparam logic signed [ACC_W-1:0] MAX_V   = ACC_W'(2 ** (W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V   = ~MAX_V;

    if (NTERMS < 1 || NTERMS > 8) begin : g_chk_nterms
        $error("kn_scale_pipe: NTERMS must be in 1..8");
    end
    for (genvar t = 0; t < NTERMS; t++) begin : g_chk_shift
        if (TERM_SHIFT[4*t +: 4] >= W) begin : g_bad
            $error("kn_scale_pipe: TERM_SHIFT entry must be below W");
        end
    end
    if (FXP_SHIFT >= ACC_W) begin : g_chk_fxp
        $error("kn_scale_pipe: FXP_SHIFT must be below the accumulator width");
    end

    logic [NTERMS*ACC_W-1:0] term_d, term_q;
    logic [L:0]              vld_d, vld_q;
    logic [L:0]              byp_d, byp_q;
    logic signed [W-1:0]     xd_d [L+1];
    logic signed [W-1:0]     xd_q [L+1];
    logic [ACC_W-1:0]        acc_sum;
    logic signed [W-1:0]     value_d, value_q;
    logic                    valid_out_d, valid_out_q;
    logic                    sat_d, sat_q;

    always_comb begin : stage1_terms
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] t;
        xe     = ACC_W'(value_in);
        t      = '0;
        term_d = '0;
        for (int unsigned i = 0; i < NTERMS; i++) begin
            t = xe <<< TERM_SHIFT[4*i +: 4];
            term_d[i*ACC_W +: ACC_W] = TERM_NEG[i] ? -t : t;
        end
    end

    // Valid, bypass and raw input travel alongside the tree so all paths share one latency.
    always_comb begin
        vld_d    = '0;
        byp_d    = '0;
        vld_d[0] = valid_in;
        byp_d[0] = bypass_in;
        xd_d[0]  = value_in;
        for (int unsigned k = 1; k <= L; k++) begin
            vld_d[k] = vld_q[k-1];
            byp_d[k] = byp_q[k-1];
            xd_d[k]  = xd_q[k-1];
        end
    end

    if (L == 0) begin : g_no_tree
        assign acc_sum = term_q;
    end else begin : g_tree
        for (genvar g = 0; g < L; g++) begin : lvl
            localparam int unsigned NIN = ops_at_level(NTERMS, g);
            logic [NIN*ACC_W-1:0]          din;
            logic [half_up(NIN)*ACC_W-1:0] dout;
            if (g == 0) begin : g_first
                assign din = term_q;
            end else begin : g_next
                assign din = lvl[g-1].dout;
            end
            kn_add_level #(
                .N     (NIN),
                .ACC_W (ACC_W)
            ) u_level (
                .clock   (clock),
                .reset_n (reset_n),
                .ce      (ce),
                .din     (din),
                .dout    (dout)
            );
        end
        assign acc_sum = lvl[L-1].dout;
    end

    always_comb begin : final_stage
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] shf;
        rnd         = $signed(acc_sum) + RND_OFS;
        shf         = rnd >>> FXP_SHIFT;
        value_d     = shf[W-1:0];
        sat_d       = 1'b0;
        valid_out_d = vld_q[L];
        if (byp_q[L]) begin
            value_d = xd_q[L];
        end else if (SAT) begin
            if (shf > MAX_V) begin
                value_d = MAX_V[W-1:0];
                sat_d   = 1'b1;
            end else if (shf < MIN_V) begin
                value_d = MIN_V[W-1:0];
                sat_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            term_q      <= '0;
            vld_q       <= '0;
            byp_q       <= '0;
            xd_q        <= '{default: '0};
            value_q     <= '0;
            valid_out_q <= 1'b0;
            sat_q       <= 1'b0;
        end else if (ce) begin
            term_q      <= term_d;
            vld_q       <= vld_d;
            byp_q       <= byp_d;
            xd_q        <= xd_d;
            value_q     <= value_d;
            valid_out_q <= valid_out_d;
            sat_q       <= sat_d;
        end
    end

    assign value_out = value_q;
    assign valid_out = valid_out_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_kn_scale_pipe.sv
// Scoreboard bench for kn_scale_pipe: default Kn instance plus a gain-2049/1024
// instance in saturating and wrapping form.
module tb_kn_scale_pipe;

    localparam int LAT_A  = 5;
    localparam int LAT_BC = 3;

    typedef struct {
        int v;
        int s;
        int c;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               ce;
    logic               valid_a, valid_b, valid_c;
    logic               bypass_in;
    logic signed [11:0] value_in;
    logic               valid_out_a, valid_out_b, valid_out_c;
    logic signed [11:0] value_out_a, value_out_b, value_out_c;
    logic               sat_a, sat_b, sat_c;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    int   total = 0;
    int   bad   = 0;
    int   cyc;
    logic ce_seen;
    int   run_a = 0;
    int   last_run_a = 0;
    logic last_exp_vld = 1'b0;
    int   last_exp_v = 0;

    int sv[8] = '{0, 1, -1, 100, 512, -512, 2047, -2048};
    int se[8] = '{0, 1, -1, 61, 311, -310, 1241, -1242};
    int iv[6] = '{1234, 1024, -7, -1024, 2047, 512};
    int ib[6] = '{1, 0, 1, 0, 1, 0};
    int ie[6] = '{1234, 621, -7, -621, 2047, 311};
    int bv[5]  = '{1024, -1024, 1, 100, 2047};
    int bb[5]  = '{0, 0, 0, 0, 1};
    int bev[5] = '{2047, -2048, 2, 200, 2047};
    int bes[5] = '{1, 1, 0, 0, 0};
    int cev[5] = '{-2047, 2047, 2, 200, 2047};
    int cv[8] = '{1024, -1024, 2047, -2048, 512, -512, 1, 100};
    int ce_e[8] = '{621, -621, 1241, -1242, 311, -310, 1, 61};

    kn_scale_pipe dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce        (ce),
        .valid_in  (valid_a),
        .bypass_in (bypass_in),
        .value_in  (value_in),
        .valid_out (valid_out_a),
        .value_out (value_out_a),
        .sat_flag  (sat_a)
    );

    kn_scale_pipe #(
        .NTERMS     (2),
        .TERM_SHIFT (32'h0000_00B0),
        .TERM_NEG   (8'h00),
        .SAT        (1'b1)
    ) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce        (ce),
        .valid_in  (valid_b),
        .bypass_in (bypass_in),
        .value_in  (value_in),
        .valid_out (valid_out_b),
        .value_out (value_out_b),
        .sat_flag  (sat_b)
    );

    kn_scale_pipe #(
        .NTERMS     (2),
        .TERM_SHIFT (32'h0000_00B0),
        .TERM_NEG   (8'h00),
        .SAT        (1'b0)
    ) dut_c (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce        (ce),
        .valid_in  (valid_c),
        .bypass_in (bypass_in),
        .value_in  (value_in),
        .valid_out (valid_out_c),
        .value_out (value_out_c),
        .sat_flag  (sat_c)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else if (ce) cyc <= cyc + 1;
    end

    always @(posedge clock) ce_seen <= ce;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n !== 1'b1) begin
            run_a = 0;
        end else if (ce_seen === 1'b1) begin
            last_exp_vld = (qa.size() != 0) && (qa[0].c + LAT_A == cyc);
            if (valid_out_a) begin
                run_a++;
                if (qa.size() == 0) begin
                    chk("a_spurious_valid", valid_out_a, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_value", value_out_a, ea.v);
                    chk("a_sat", sat_a, ea.s);
                    chk("a_latency", cyc - ea.c, LAT_A);
                    last_exp_v = ea.v;
                end
            end else begin
                if (run_a != 0) last_run_a = run_a;
                run_a = 0;
            end
        end else if (ce_seen === 1'b0) begin
            chk("a_frozen_valid", valid_out_a, last_exp_vld);
            if (last_exp_vld) chk("a_frozen_value", value_out_a, last_exp_v);
        end
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && ce_seen === 1'b1 && valid_out_b) begin
            if (qb.size() == 0) begin
                chk("b_spurious_valid", valid_out_b, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_value", value_out_b, eb.v);
                chk("b_sat", sat_b, eb.s);
                chk("b_latency", cyc - eb.c, LAT_BC);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && ce_seen === 1'b1 && valid_out_c) begin
            if (qc.size() == 0) begin
                chk("c_spurious_valid", valid_out_c, 0);
            end else begin
                ec = qc.pop_front();
                chk("c_value", value_out_c, ec.v);
                chk("c_sat", sat_c, ec.s);
                chk("c_latency", cyc - ec.c, LAT_BC);
            end
        end
    end

    task automatic send_a(input int v, input int b, input int ev, input int es);
        value_in  = v[11:0];
        bypass_in = (b != 0);
        valid_a   = 1'b1;
        valid_b   = 1'b0;
        valid_c   = 1'b0;
        qa.push_back('{v: ev, s: es, c: cyc});
        do @(negedge clock); while (ce_seen !== 1'b1);
    endtask

    task automatic send_bc(input int v, input int b, input int evb, input int esb, input int evc);
        value_in  = v[11:0];
        bypass_in = (b != 0);
        valid_a   = 1'b0;
        valid_b   = 1'b1;
        valid_c   = 1'b1;
        qb.push_back('{v: evb, s: esb, c: cyc});
        qc.push_back('{v: evc, s: 0, c: cyc});
        do @(negedge clock); while (ce_seen !== 1'b1);
    endtask

    task automatic idle(input int n);
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        valid_c   = 1'b0;
        bypass_in = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        idle(0);
        for (int i = 0; i < 60; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("drain_c", qc.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b1;
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        valid_c   = 1'b0;
        bypass_in = 1'b0;
        value_in  = '0;
        repeat (3) @(negedge clock);
        chk("rst_valid_a", valid_out_a, 0);
        chk("rst_value_a", value_out_a, 0);
        chk("rst_sat_a", sat_a, 0);
        chk("rst_valid_b", valid_out_b, 0);
        chk("rst_value_b", value_out_b, 0);
        chk("rst_valid_c", valid_out_c, 0);
        reset_n = 1'b1;
        idle(3);

        send_a(1024, 0, 621, 0);
        idle(6);
        send_a(-1024, 0, -621, 0);
        send_a(2047, 0, 1241, 0);
        send_a(-2048, 0, -1242, 0);
        drain();

        for (int i = 0; i < 8; i++) send_a(sv[i], 0, se[i], 0);
        drain();
        chk("a_stream_run", last_run_a, 8);

        for (int i = 0; i < 6; i++) send_a(iv[i], ib[i], ie[i], 0);
        drain();

        for (int i = 0; i < 5; i++) send_bc(bv[i], bb[i], bev[i], bes[i], cev[i]);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) send_a(cv[i], 0, ce_e[i], 0);
            end
            begin
                repeat (6) @(negedge clock);
                ce = 1'b0;
                repeat (3) @(negedge clock);
                ce = 1'b1;
            end
        join
        drain();
        chk("a_ce_run", last_run_a, 8);

        for (int i = 0; i < 6; i++) send_a(cv[i], 0, ce_e[i], 0);
        idle(0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid_a", valid_out_a, 0);
        chk("async_rst_value_a", value_out_a, 0);
        chk("async_rst_sat_a", sat_a, 0);
        qa.delete();
        qb.delete();
        qc.delete();
        @(negedge clock);
        reset_n = 1'b1;
        idle(12);
        send_a(512, 0, 311, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
